// File: rtl/base_abcast_reg_if.sv
// Stream bundle for the registered broadcast stage: one upstream valid/ready/data
// and `no` downstream valid/ready lanes sharing a single data bus.
interface base_abcast_reg_if #(
    parameter int width = 1,
    parameter int no    = 2
) ();
    logic             i_v;
    logic             i_r;
    logic [width-1:0] i_d;
    logic [no-1:0]    o_v;
    logic [no-1:0]    o_r;
    logic [width-1:0] o_d;

    // master: the environment around the stage (upstream producer and all consumers)
    modport master (
        output i_v, i_d, o_r,
        input  i_r, o_v, o_d
    );

    modport slave (
        input  i_v, i_d, o_r,
        output i_r, o_v, o_d
    );
endinterface

// File: rtl/base_abcast_reg.sv
// One-entry registered broadcast: a captured beat is offered to every consumer
// in parallel and retires once all of them have taken it.
module base_abcast_reg #(
    parameter int width = 1,
    parameter int no    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    base_abcast_reg_if.slave  bus
);

    logic             full;
    logic [no-1:0]    done;
    logic [width-1:0] dreg;

    logic [no-1:0]    xfer;
    logic             complete;
    logic             acc;

    assign bus.o_v = {no{full}} & ~done;
    assign bus.o_d = dreg;

    assign xfer     = bus.o_v & bus.o_r;
    assign complete = full & (&(done | xfer));

    // Refill is allowed in the same cycle the last consumer takes the beat.
    assign bus.i_r = reset_n & (~full | complete);
    assign acc     = bus.i_v & bus.i_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            done <= '0;
            dreg <= '0;
        end else if (acc) begin
            full <= 1'b1;
            done <= '0;
            dreg <= bus.i_d;
        end else if (complete) begin
            full <= 1'b0;
            done <= '0;
        end else if (full) begin
            done <= done | xfer;
        end
    end

endmodule

// File: doc/base_abcast_reg.md
# base_abcast_reg

Registered one-to-many broadcast stage for valid/ready streams. A single input beat is captured into a one-entry holding register and offered to `no` consumers in parallel. Each consumer takes the beat independently and at its own pace. The entry retires only once every consumer has taken it. It sits directly upstream of the all-or-nothing synchronising combiner: it lets independent consumers drift apart by up to one beat before they are re-joined downstream, and it breaks the `i_v`->`o_v` combinational path.

## Interface
- `width`, default 1: data width of the broadcast beat.
- `no`, default 2: number of output consumers, minimum 1.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low; the polarity and synchronicity are fixed.
- `i_v`  in  1  input beat valid.
- `i_r`  out  1  input ready.
- `i_d`  in  [0:width-1]  input beat data.
- `o_v`  out  [0:no-1]  per-consumer valid.
- `o_r`  in  [0:no-1]  per-consumer ready.
- `o_d`  out  [0:width-1]  broadcast data, shared by all consumers.

## Operation
State:
- `full`: 1 bit.
- `done[0:no-1]`: per-consumer "already taken" mask.
- `dreg[0:width-1]`: held data.

Outputs and handshake terms:
- `o_v[k] = full & ~done[k]`.
- `o_d = dreg`.
- Consumer k transfers when `o_v[k] & o_r[k]`; this is `xfer[k]`.
- `complete = full & &(done | xfer)`: the last outstanding consumer(s) take the beat in this cycle.
- `i_r = reset_n & (~full | complete)`. The entry may refill in the same cycle it retires.
- Input accept: `acc = i_v & i_r`.

Next state, priority as listed:
- `acc`: `dreg <= i_d`, `full <= 1`, `done <= 0`.
- Else `complete`: `full <= 0`, `done <= 0`; `dreg` is held.
- Else, while `full`: `done <= done | xfer`.
- Else: hold.

Rules and boundary conditions:
- **Simultaneous events:** if the final consumer takes the beat in the same cycle a new input arrives, the entry retires and reloads in that one cycle, with no bubble.
- **Stability:** `dreg` changes only on `acc`. `o_d` is therefore stable for the entire time any `o_v[k]` is 1.
- **Once per consumer:** a consumer that has taken the beat sees `o_v[k]=0` until the next beat loads. Its `o_r[k]` is ignored meanwhile.
- **Sticky valid:** once `o_v[k]` is 1 it stays 1 until `xfer[k]`. It never drops otherwise.
- **`no=1`:** the block is a plain one-entry pipeline register with full throughput.
- **Reset mid-operation:** the asynchronous assert clears `full`, `done` and `dreg` to 0 immediately. A partially delivered beat is discarded and is not replayed.
- **Protocol assumption:** `i_v` and `i_d` are held stable by the upstream until accepted. The block does not check this.

## Timing
Reset values (while `reset_n=0` and after it):
- `o_v = 0`, `o_d = 0`, `i_r = 0`.
- `i_r` becomes 1 combinationally once `reset_n` deasserts.

Latency and throughput:
- Input accept to `o_v` high is one cycle: a beat accepted at edge N is visible from edge N.
- Throughput is one beat per cycle while all `o_r` are 1.

Combinational paths:
- `o_r` -> `i_r` exists through `complete`.
- There is no combinational path from `i_v` or `i_d` to any output.
- `o_v` and `o_d` come from flops only.

## Test plan
- **Reset:** hold `reset_n=0` for 3 cycles with `i_v=1`, `i_d=0x5`. Required: `o_v=0`, `o_d=0` and `i_r=0` throughout. `i_r=1` the cycle `reset_n` rises. No beat is captured during reset.
- **Streaming** (`no=3`, `width=8`, all `o_r=1`): send 0x11, 0x22, 0x33 back-to-back. Required: `o_v=111` for 3 consecutive cycles carrying `o_d` 0x11, 0x22, 0x33. `i_r` stays 1. `o_v` drops to 000 after the last beat.
- **Staggered consumers** (`no=2`): load 0xA5 with `o_r=10` for 3 cycles, then `o_r=11`, while `i_v=1` with 0x5A queued. Required:
  - cycle 1: `o_v=11`;
  - cycles 2-3: `o_v=01`, `o_d=0xA5`, `i_r=0`;
  - when `o_r[1]` rises: `i_r=1` in that cycle;
  - next cycle: `o_v=11`, `o_d=0x5A`.
- **Ignored ready:** with `done=10` (consumer 0 has taken the beat), toggle `o_r[0]` for 4 cycles while `o_r[1]=0`. Required: `o_v[0]` stays 0, no extra transfer, and `done` unchanged.
- **Reset mid-beat:** with beat 0x3C delivered to consumer 0 only, pulse `reset_n` low for part of a cycle. Required: `o_v=00` immediately, 0x3C is never re-offered, and the next accepted beat appears normally on both outputs.
- **`no=1`** with random `i_v`/`o_r` over 1000 cycles. Required: the output sequence equals the input sequence, with no loss or duplication.
